// File: rtl/pcie_tl_counters_pkg.sv
// Shared types and defaults for the PCIe TL per-FIFO pop counters.
package pcie_tl_counters_pkg;

  // FSM encoding, exported as-is on cuenta_est.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_COUNT = 2'd2,
    ST_READY = 2'd3
  } state_t;

  localparam int NUM_CNT_DEF = 4;
  localparam int CNT_W_DEF   = 5;
  localparam int IDX_W_DEF   = 3;

  // idx value that selects the sum of all counters.
  localparam int IDX_SUM     = NUM_CNT_DEF;

endpackage

// File: rtl/pcie_tl_counters_cnt_slice.sv
// One pop counter. Wraps by default; sticks at all-ones when CNT_SAT_EN is defined.
module cnt_slice #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc; reset clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc) begin
`ifdef CNT_SAT_EN
      if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
`else
      cnt <= cnt + 1'b1;
`endif
    end
  end

endmodule

// File: rtl/pcie_tl_counters.sv
// PCIe TL per-FIFO transaction counters with a registered read port.
// Optional feature macro: CNT_SAT_EN (counters and sum saturate instead of wrapping).
import pcie_tl_counters_pkg::*;

module pcie_tl_counters #(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CNT-1:0] pop,
  input  logic               idle,
  input  logic               req,
  input  logic [IDX_W-1:0]   idx,
  output logic [CNT_W-1:0]   cuenta,
  output logic               valid,
  output logic               err,
  output logic [1:0]         cuenta_est
);

  // Sum needs headroom for NUM_CNT full-scale counters before truncation/saturation.
  localparam int SUM_W = CNT_W + $clog2(NUM_CNT + 1);

  state_t state, state_nxt;

  logic [NUM_CNT-1:0]            inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
  logic [SUM_W-1:0]              sum_full;
  logic [CNT_W-1:0]              sum_out;
  logic [CNT_W-1:0]              sel_cnt;
  logic [CNT_W-1:0]              rd_data;
  logic                          rd_hit;
  logic                          idx_oor;

  // Counters are frozen only while the FSM sits in RESET.
  assign inc = (state != ST_RESET) ? pop : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_slice
      cnt_slice #(.CNT_W(CNT_W)) u_slice (
        .clk   (clk),
        .reset (reset),
        .inc   (inc[gi]),
        .cnt   (cnt[gi])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RESET;
    else       state <= state_nxt;
  end

  // Next-state: INIT lasts one cycle, then idle steers between COUNT and READY.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_INIT;
      ST_INIT,
      ST_COUNT,
      ST_READY: state_nxt = idle ? ST_READY : ST_COUNT;
      default:  state_nxt = ST_RESET;
    endcase
  end

  assign cuenta_est = state;

  // Sum of all counters, wrapped or saturated to CNT_W.
  always_comb begin
    sum_full = '0;
    for (int i = 0; i < NUM_CNT; i++) sum_full = sum_full + SUM_W'(cnt[i]);
`ifdef CNT_SAT_EN
    sum_out = (sum_full > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum_full[CNT_W-1:0];
`else
    sum_out = sum_full[CNT_W-1:0];
`endif
  end

  // Read mux: single counter, sum, or zero for an out-of-range index.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_CNT; i++)
      if (int'(idx) == i) sel_cnt = cnt[i];
    idx_oor = int'(idx) > NUM_CNT;
    if (int'(idx) < NUM_CNT)       rd_data = sel_cnt;
    else if (int'(idx) == NUM_CNT) rd_data = sum_out;
    else                           rd_data = '0;
  end

  assign rd_hit = (state == ST_READY) && req;

  // Output registers: rd_data samples pre-increment counts; cuenta holds when no read.
  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else if (rd_hit) begin
      cuenta <= rd_data;
      valid  <= 1'b1;
      err    <= idx_oor;
    end else begin
      valid  <= 1'b0;
      err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcie_tl_counters.sv
// Directed self-checking bench for pcie_tl_counters (default parameters).
module tb_pcie_tl_counters;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pop;
  logic       idle;
  logic       req;
  logic [2:0] idx;
  logic [4:0] cuenta;
  logic       valid;
  logic       err;
  logic [1:0] cuenta_est;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pcie_tl_counters dut (
    .clk        (clk),
    .reset      (reset),
    .pop        (pop),
    .idle       (idle),
    .req        (req),
    .idx        (idx),
    .cuenta     (cuenta),
    .valid      (valid),
    .err        (err),
    .cuenta_est (cuenta_est)
  );

  // Advance one edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release with idle=0; leaves the FSM in COUNT with all counters 0.
  task automatic do_reset();
    reset = 1'b1; pop = '0; req = 1'b0; idx = '0; idle = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  // Pulse each pop bit the given number of times, in parallel.
  task automatic load(input int n0, input int n1, input int n2, input int n3);
    int m;
    m = n0;
    if (n1 > m) m = n1;
    if (n2 > m) m = n2;
    if (n3 > m) m = n3;
    for (int k = 0; k < m; k++) begin
      pop = {(k < n3), (k < n2), (k < n1), (k < n0)};
      tick();
    end
    pop = '0;
  endtask

  task automatic to_ready();
    idle = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; pop = 4'hF; req = 1'b1; idx = '0; idle = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_run++;
      if (cuenta !== 5'd0 || valid !== 1'b0 || err !== 1'b0 || cuenta_est !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d cuenta=%0d valid=%b err=%b est=%0d exp 0/0/0/0",
                 c, cuenta, valid, err, cuenta_est);
      end
    end
    pop = '0; req = 1'b0;
    reset = 1'b0;
    tick();
    n_run++;
    if (cuenta_est !== 2'd1) begin
      n_fail++; $display("FAIL reset_to_init est=%0d exp 1", cuenta_est);
    end
    tick();
    n_run++;
    if (cuenta_est !== 2'd2) begin
      n_fail++; $display("FAIL init_to_count est=%0d exp 2", cuenta_est);
    end
  endtask

  task automatic test_basic_read();
    do_reset();
    load(4, 0, 1, 0);
    to_ready();
    n_run++;
    if (cuenta_est !== 2'd3) begin
      n_fail++; $display("FAIL count_to_ready est=%0d exp 3", cuenta_est);
    end
    req = 1'b1; idx = 3'd0;
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== 5'd4 || err !== 1'b0) begin
      n_fail++; $display("FAIL rd_idx0 valid=%b cuenta=%0d err=%b exp 1/4/0", valid, cuenta, err);
    end
    idx = 3'd2;
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== 5'd1) begin
      n_fail++; $display("FAIL rd_idx2 valid=%b cuenta=%0d exp 1/1", valid, cuenta);
    end
    req = 1'b0;
    tick();
    n_run++;
    if (valid !== 1'b0 || cuenta !== 5'd1) begin
      n_fail++; $display("FAIL rd_drop valid=%b cuenta=%0d exp 0/1", valid, cuenta);
    end
  endtask

  task automatic test_sum_err();
    do_reset();
    load(3, 1, 2, 5);
    to_ready();
    req = 1'b1; idx = 3'd4;
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== 5'd11 || err !== 1'b0) begin
      n_fail++; $display("FAIL rd_sum valid=%b cuenta=%0d err=%b exp 1/11/0", valid, cuenta, err);
    end
    idx = 3'd6;
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== 5'd0 || err !== 1'b1) begin
      n_fail++; $display("FAIL rd_idx6 valid=%b cuenta=%0d err=%b exp 1/0/1", valid, cuenta, err);
    end
    idx = 3'd5;
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== 5'd0 || err !== 1'b1) begin
      n_fail++; $display("FAIL rd_idx5 valid=%b cuenta=%0d err=%b exp 1/0/1", valid, cuenta, err);
    end
    idx = 3'd3;
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== 5'd5 || err !== 1'b0) begin
      n_fail++; $display("FAIL rd_idx3 valid=%b cuenta=%0d err=%b exp 1/5/0", valid, cuenta, err);
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [4:0] exp_c1, exp_sum;
`ifdef CNT_SAT_EN
    exp_c1  = 5'd31;
    exp_sum = 5'd31;
`else
    exp_c1  = 5'd1;
    exp_sum = 5'd3;
`endif
    do_reset();
    load(0, 33, 0, 0);
    to_ready();
    req = 1'b1; idx = 3'd1;
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== exp_c1) begin
      n_fail++; $display("FAIL wrap_c1 valid=%b cuenta=%0d exp 1/%0d", valid, cuenta, exp_c1);
    end
    req = 1'b0;
    do_reset();
    load(20, 15, 0, 0);
    to_ready();
    req = 1'b1; idx = 3'd4;
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== exp_sum) begin
      n_fail++; $display("FAIL sum_ovf valid=%b cuenta=%0d exp 1/%0d", valid, cuenta, exp_sum);
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_pop_during_read();
    do_reset();
    load(0, 0, 0, 7);
    to_ready();
    req = 1'b1; idx = 3'd3; pop = 4'b1000;
    tick();
    pop = '0;
    n_run++;
    if (valid !== 1'b1 || cuenta !== 5'd7) begin
      n_fail++; $display("FAIL rd_pre_inc valid=%b cuenta=%0d exp 1/7", valid, cuenta);
    end
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== 5'd8) begin
      n_fail++; $display("FAIL rd_post_inc valid=%b cuenta=%0d exp 1/8", valid, cuenta);
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_negative();
    do_reset();
    load(2, 0, 0, 0);
    req = 1'b1; idx = 3'd0;
    tick();
    n_run++;
    if (valid !== 1'b0 || cuenta_est !== 2'd2) begin
      n_fail++; $display("FAIL rd_not_ready valid=%b est=%0d exp 0/2", valid, cuenta_est);
    end
    to_ready();
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== 5'd2) begin
      n_fail++; $display("FAIL rd_before_rst valid=%b cuenta=%0d exp 1/2", valid, cuenta);
    end
    reset = 1'b1;
    tick();
    n_run++;
    if (valid !== 1'b0 || cuenta !== 5'd0 || cuenta_est !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid_read valid=%b cuenta=%0d est=%0d exp 0/0/0",
                         valid, cuenta, cuenta_est);
    end
    reset = 1'b0;
    tick();
    tick();
    n_run++;
    if (valid !== 1'b0 || cuenta_est !== 2'd3) begin
      n_fail++; $display("FAIL rst_recover valid=%b est=%0d exp 0/3", valid, cuenta_est);
    end
    tick();
    n_run++;
    if (valid !== 1'b1 || cuenta !== 5'd0) begin
      n_fail++; $display("FAIL rd_after_rst valid=%b cuenta=%0d exp 1/0", valid, cuenta);
    end
    req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; pop = '0; idle = 1'b0; req = 1'b0; idx = '0;
    test_reset();
    test_basic_read();
    test_sum_err();
    test_wrap();
    test_pop_during_read();
    test_negative();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
